// File: rtl/reg_cmd_master_pkg.sv
// Shared constants and state encoding for the register command master.
// Frame bytes and FSM states are reused by host-side drivers.
package reg_cmd_master_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hAA;
  localparam logic [7:0] CMD_RD    = 8'h01;
  localparam logic [7:0] CMD_WR    = 8'h02;
  localparam logic [7:0] ACK_BYTE  = 8'hA5;
  localparam logic [7:0] NAK_BYTE  = 8'h5A;

  typedef enum logic [2:0] {
    ST_HUNT     = 3'd0,
    ST_CMD      = 3'd1,
    ST_ADDR     = 3'd2,
    ST_DATA     = 3'd3,
    ST_ISSUE    = 3'd4,
    ST_WAIT     = 3'd5,
    ST_SEND_HDR = 3'd6,
    ST_SEND_DAT = 3'd7
  } state_e;

endpackage

// File: rtl/cycle_timer.sv
// Saturating cycle counter; expired once LIMIT enabled cycles elapsed.
// Ports: clk, rst (sync, high), clear, enable -> expired.
module cycle_timer #(
  parameter int unsigned LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 2);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (enable && cnt_q != LIM)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == LIM);

endmodule

// File: rtl/reg_cmd_master.sv
// Parses SYNC/CMD/ADDR/[DATA] byte frames, issues one register access,
// returns ACK+data or NAK+00. Ports: in_* (RX bytes), out_* (TX bytes),
// address/rx_* (issue to responder), tx_* (reply), drop_cnt.
module reg_cmd_master
  import reg_cmd_master_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT = 8,
  parameter int unsigned IDLE_TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] address,
  output logic       address_valid,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic [7:0] drop_cnt
);

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdat_q, wdat_d;
  logic       is_wr_q, is_wr_d;
  logic [7:0] hdr_q, hdr_d;
  logic [7:0] dat_q, dat_d;
  logic [7:0] drop_q, drop_d;
  logic       drop;
  logic       in_frame;
  logic       state_chg;
  logic       idle_exp;
  logic       resp_exp;

  assign in_frame  = (state_q == ST_CMD) ||
                     (state_q == ST_ADDR) ||
                     (state_q == ST_DATA);
  assign state_chg = (state_d != state_q);

  // Timers expire on the last allowed cycle so the FSM
  // leaves exactly after LIMIT silent / waiting cycles.
  cycle_timer #(.LIMIT(IDLE_TIMEOUT - 1)) u_idle (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_chg | in_valid),
    .enable  (in_frame),
    .expired (idle_exp)
  );

  // Counts WAIT cycles only; cycle k after ISSUE sees count k-1.
  cycle_timer #(.LIMIT(RESP_TIMEOUT - 1)) u_resp (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_chg),
    .enable  (state_q == ST_WAIT),
    .expired (resp_exp)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    is_wr_d = is_wr_q;
    hdr_d   = hdr_q;
    dat_d   = dat_q;
    drop    = 1'b0;
    unique case (state_q)
      ST_HUNT: begin
        if (in_valid) begin
          if (in_data == SYNC_BYTE) state_d = ST_CMD;
          else                      drop    = 1'b1;
        end
      end
      ST_CMD: begin
        if (in_valid) begin
          if (in_data == CMD_RD) begin
            is_wr_d = 1'b0;
            wdat_d  = '0;
            state_d = ST_ADDR;
          end else if (in_data == CMD_WR) begin
            is_wr_d = 1'b1;
            state_d = ST_ADDR;
          end else begin
            drop    = 1'b1;
            state_d = ST_HUNT;
          end
        end else if (idle_exp) begin
          drop    = 1'b1;
          state_d = ST_HUNT;
        end
      end
      ST_ADDR: begin
        if (in_valid) begin
          addr_d  = in_data;
          state_d = is_wr_q ? ST_DATA : ST_ISSUE;
        end else if (idle_exp) begin
          drop    = 1'b1;
          state_d = ST_HUNT;
        end
      end
      ST_DATA: begin
        if (in_valid) begin
          wdat_d  = in_data;
          state_d = ST_ISSUE;
        end else if (idle_exp) begin
          drop    = 1'b1;
          state_d = ST_HUNT;
        end
      end
      ST_ISSUE: begin
        // tx_valid here is a stale reply and is ignored
        drop    = in_valid;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        drop = in_valid;
        if (tx_valid) begin
          hdr_d   = ACK_BYTE;
          dat_d   = tx_data;
          state_d = ST_SEND_HDR;
        end else if (resp_exp) begin
          hdr_d   = NAK_BYTE;
          dat_d   = '0;
          state_d = ST_SEND_HDR;
        end
      end
      ST_SEND_HDR: begin
        drop = in_valid;
        if (out_ready) state_d = ST_SEND_DAT;
      end
      ST_SEND_DAT: begin
        drop = in_valid;
        if (out_ready) state_d = ST_HUNT;
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (drop && drop_q != 8'hFF)
      drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HUNT;
      addr_q  <= '0;
      wdat_q  <= '0;
      is_wr_q <= 1'b0;
      hdr_q   <= '0;
      dat_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      is_wr_q <= is_wr_d;
      hdr_q   <= hdr_d;
      dat_q   <= dat_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    out_data = '0;
    unique case (1'b1)
      (state_q == ST_SEND_HDR): out_data = hdr_q;
      (state_q == ST_SEND_DAT): out_data = dat_q;
      default:                  out_data = '0;
    endcase
  end

  assign out_valid     = (state_q == ST_SEND_HDR) ||
                         (state_q == ST_SEND_DAT);
  assign address_valid = (state_q == ST_ISSUE);
  assign rx_valid      = address_valid & is_wr_q;
  assign address       = addr_q;
  assign rx_data       = wdat_q;
  assign drop_cnt      = drop_q;

endmodule
